// File: rtl/raster_sequencer.sv
// Draw-engine controller: walks the pixels of one CLEAR/PIXEL/RECT/LINE command and
// streams them to the framebuffer over a valid/ready handshake, one pixel per accepted beat.
module raster_sequencer #(
   parameter int COORD_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         command,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   input  logic [COORD_W-1:0] rect_width,
   input  logic [COORD_W-1:0] rect_height,
   output logic               pix_we,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_val,
   output logic               busy,
   output logic               done,
   output logic               cmd_dropped
);
   localparam int E = COORD_W + 3;
   localparam logic [COORD_W-1:0] MAX = '1;
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PIXEL, S_RECT, S_LINE, S_DONE} state_t;

   state_t r_state, w_nstate;
   logic               w_accept, w_consume, w_last;
   logic [COORD_W-1:0] r_x, r_y, r_x0, r_xe, r_ye, r_x2, r_y2;
   logic               r_sx, r_sy, r_val, r_we, r_ready, r_busy, r_done, r_drop;
   logic signed [E-1:0] r_err, r_dx, r_dy;
   logic signed [E-1:0] w_e2, w_ddx, w_ddy, w_adx, w_ady, w_err_nx;
   logic               w_stepx, w_stepy;
   logic [COORD_W:0]   w_sumx, w_sumy;
   logic [COORD_W-1:0] w_xe, w_ye;

   // RECT extents are summed one bit wider so an overflowing edge clips to the grid border.
   assign w_sumx = {1'b0, x1} + {1'b0, rect_width};
   assign w_sumy = {1'b0, y1} + {1'b0, rect_height};
   assign w_xe   = w_sumx[COORD_W] ? MAX : w_sumx[COORD_W-1:0];
   assign w_ye   = w_sumy[COORD_W] ? MAX : w_sumy[COORD_W-1:0];

   assign w_ddx = $signed({{3{1'b0}}, x2}) - $signed({{3{1'b0}}, x1});
   assign w_ddy = $signed({{3{1'b0}}, y2}) - $signed({{3{1'b0}}, y1});
   assign w_adx = (w_ddx < 0) ? -w_ddx : w_ddx;
   assign w_ady = (w_ddy < 0) ? -w_ddy : w_ddy;

   // Both Bresenham decisions are taken from the same pre-update error term.
   assign w_e2     = r_err + r_err;
   assign w_stepx  = (w_e2 >= r_dy);
   assign w_stepy  = (w_e2 <= r_dx);
   assign w_err_nx = r_err + (w_stepx ? r_dy : '0) + (w_stepy ? r_dx : '0);

   assign w_consume = r_we & pix_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_accept = 1'b1;
               case (command)
                  2'd0:    w_nstate = S_CLEAR;
                  2'd1:    w_nstate = S_PIXEL;
                  2'd2:    w_nstate = S_RECT;
                  default: w_nstate = S_LINE;
               endcase
            end
         end
         S_CLEAR: w_last = (r_x == MAX) && (r_y == MAX);
         S_PIXEL: w_last = 1'b1;
         S_RECT:  w_last = (r_x == r_xe) && (r_y == r_ye);
         S_LINE:  w_last = (r_x == r_x2) && (r_y == r_y2);
         S_DONE:  w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
      if (w_consume && w_last) w_nstate = S_DONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_we    <= (w_nstate == S_CLEAR) || (w_nstate == S_PIXEL) ||
                    (w_nstate == S_RECT)  || (w_nstate == S_LINE);
         r_ready <= (w_nstate == S_IDLE);
         r_busy  <= (w_nstate != S_IDLE);
         r_done  <= (w_nstate == S_DONE);
         r_drop  <= cmd_valid & ~r_ready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0; r_y <= '0; r_x0 <= '0; r_xe <= '0; r_ye <= '0;
         r_x2 <= '0; r_y2 <= '0; r_sx <= 1'b0; r_sy <= 1'b0; r_val <= 1'b0;
         r_err <= '0; r_dx <= '0; r_dy <= '0;
      end else if (w_accept) begin
         r_x   <= (command == 2'd0) ? '0 : x1;
         r_y   <= (command == 2'd0) ? '0 : y1;
         r_val <= (command != 2'd0);
         r_x0  <= x1;
         r_xe  <= w_xe;
         r_ye  <= w_ye;
         r_x2  <= x2;
         r_y2  <= y2;
         r_sx  <= (w_ddx < 0);
         r_sy  <= (w_ddy < 0);
         r_dx  <= w_adx;
         r_dy  <= -w_ady;
         r_err <= w_adx - w_ady;
      end else if (w_consume && !w_last) begin
         case (r_state)
            S_CLEAR: begin
               if (r_x == MAX) begin r_x <= '0; r_y <= r_y + ONE; end
               else r_x <= r_x + ONE;
            end
            S_RECT: begin
               if (r_x == r_xe) begin r_x <= r_x0; r_y <= r_y + ONE; end
               else r_x <= r_x + ONE;
            end
            S_LINE: begin
               r_err <= w_err_nx;
               if (w_stepx) r_x <= r_sx ? r_x - ONE : r_x + ONE;
               if (w_stepy) r_y <= r_sy ? r_y - ONE : r_y + ONE;
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready   = r_ready;
   assign busy        = r_busy;
   assign done        = r_done;
   assign cmd_dropped = r_drop;
   assign pix_we      = r_we;
   assign pix_x       = r_x;
   assign pix_y       = r_y;
   assign pix_val     = r_val;
endmodule
